asteroid_field_ctrl: RTL

Parametrised successor to the fixed four-asteroid split controller. It manages NUM_SLOTS asteroid slots with a general split tree: a hit LARGE or MED asteroid shrinks and spawns a child into the lowest free slot. Per-frame hits are resolved by a sequential slot scan after vsync, and frame points are produced in BCD. It sits between the torpedo logic and the per-slot Asteroid_unit instances, and drives their size, relocate and parent-position selection.

---
 rtl/asteroid_field_ctrl_pkg.sv | 26 ++
 rtl/asteroid_field_ctrl_bcd_add3.sv | 26 ++
 rtl/asteroid_field_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/asteroid_field_ctrl_pkg.sv
// Shared types and constants for the asteroid field controller.
// Slot sizes, FSM states, BCD point values and the per-level seed pattern.
package asteroid_field_ctrl_pkg;

  typedef enum logic [1:0] {
    AST_NONE  = 2'd0,
    AST_SMALL = 2'd1,
    AST_MED   = 2'd2,
    AST_LARGE = 2'd3
  } ast_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } fsm_state_t;

  localparam logic [11:0] PTS_LARGE = 12'h020;
  localparam logic [11:0] PTS_MED   = 12'h050;
  localparam logic [11:0] PTS_SMALL = 12'h100;

  function automatic ast_slot_t seed_size(input int idx, input int n_large);
    return (idx < n_large) ? AST_LARGE : AST_NONE;
  endfunction

endpackage

// File: rtl/asteroid_field_ctrl_bcd_add3.sv
// Three-digit BCD adder; any carry out of the hundreds digit clamps to 999.
module asteroid_field_ctrl_bcd_add3 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] sum
);

  logic [4:0]  dsum [3];
  logic [3:0]  carry;
  logic [11:0] raw;

  always_comb begin
    carry = '0;
    raw   = '0;
    for (int d = 0; d < 3; d++) begin
      dsum[d] = 5'(a[4*d +: 4]) + 5'(b[4*d +: 4]) + 5'(carry[d]);
      if (dsum[d] > 5'd9) begin
        dsum[d]    = dsum[d] + 5'd6;
        carry[d+1] = 1'b1;
      end
      raw[4*d +: 4] = dsum[d][3:0];
    end
    sum = carry[3] ? 12'h999 : raw;
  end

endmodule

// File: rtl/asteroid_field_ctrl.sv
// Asteroid slot manager: accumulates torpedo hits per frame, resolves splits with a
// one-slot-per-cycle scan after vsync, and commits sizes, reload pulses and BCD points.
module asteroid_field_ctrl
  import asteroid_field_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int NUM_LARGE = 2,
  parameter int T_NUM     = 4
) (
  input  logic                                   clk,
  input  logic                                   resetN,
  input  logic                                   vsync,
  input  logic                                   game_begin,
  input  logic                                   game_over,
  input  logic                                   new_level,
  input  logic [NUM_SLOTS-1:0]                   hit_en,
  input  logic [T_NUM-1:0]                       torpedo_en,
  output logic [T_NUM-1:0]                       torpedo_hit,
  output logic [2*NUM_SLOTS-1:0]                 slot_size,
  output logic [NUM_SLOTS-1:0]                   slot_new,
  output logic [NUM_SLOTS*$clog2(NUM_SLOTS)-1:0] slot_parent,
  output logic [11:0]                            ast_points,
  output logic                                   points_valid,
  output logic                                   level_clear,
  output logic [7:0]                             drop_cnt
);

  localparam int PW = $clog2(NUM_SLOTS);
  localparam logic [NUM_SLOTS-1:0] SEED_MASK = NUM_SLOTS'((64'd1 << NUM_LARGE) - 64'd1);

  fsm_state_t state_q, state_d;

  ast_slot_t      size_q      [NUM_SLOTS];
  ast_slot_t      work_size   [NUM_SLOTS];
  logic [PW-1:0]  parent_q    [NUM_SLOTS];
  logic [PW-1:0]  work_parent [NUM_SLOTS];

  logic [PW-1:0]        k;
  logic [NUM_SLOTS-1:0] live, live_hit, cur_hit;
  logic [NUM_SLOTS-1:0] hit_acc, hits_frame, free_cap, alloc, new_mask, avail;
  logic                 pend_nl, reseed, found, work_empty;
  logic                 hit_k, score_en, capture, last_k;
  logic [PW-1:0]        fidx;
  ast_slot_t            cur_size, next_size, child_size;
  logic [11:0]          pts, step_pts, pts_sum;

  always_comb begin
    live = '0;
    for (int i = 0; i < NUM_SLOTS; i++) live[i] = (size_q[i] != AST_NONE);
  end

  assign live_hit    = hit_en & live & {NUM_SLOTS{~game_over}};
  assign cur_hit     = live_hit & {NUM_SLOTS{|torpedo_en}};
  assign torpedo_hit = torpedo_en & {T_NUM{|live_hit}};

  assign capture  = (state_q == ST_IDLE) & vsync;
  assign last_k   = (k == PW'(NUM_SLOTS - 1));
  assign score_en = game_begin & ~game_over;

  always_comb begin
    cur_size   = work_size[k];
    hit_k      = hits_frame[k] & ~reseed;
    next_size  = AST_NONE;
    child_size = AST_NONE;
    step_pts   = '0;
    case (cur_size)
      AST_LARGE: begin next_size = AST_MED;   child_size = AST_MED;   step_pts = PTS_LARGE; end
      AST_MED:   begin next_size = AST_SMALL; child_size = AST_SMALL; step_pts = PTS_MED;   end
      AST_SMALL: begin next_size = AST_NONE;  child_size = AST_NONE;  step_pts = PTS_SMALL; end
      default:   ;
    endcase
  end

  // Lowest slot that was empty at capture and not yet handed out this frame.
  always_comb begin
    avail = free_cap & ~alloc;
    found = 1'b0;
    fidx  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (avail[i]) begin
        found = 1'b1;
        fidx  = PW'(i);
      end
    end
  end

  always_comb begin
    work_empty = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (work_size[i] != AST_NONE) work_empty = 1'b0;
    end
  end

  asteroid_field_ctrl_bcd_add3 u_bcd_add3 (
    .a   (pts),
    .b   (step_pts),
    .sum (pts_sum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (vsync) state_d = ST_SCAN;
      ST_SCAN:   if (last_k) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      k            <= '0;
      hit_acc      <= '0;
      hits_frame   <= '0;
      free_cap     <= '0;
      alloc        <= '0;
      new_mask     <= '0;
      pend_nl      <= 1'b0;
      reseed       <= 1'b0;
      pts          <= '0;
      drop_cnt     <= '0;
      ast_points   <= '0;
      points_valid <= 1'b0;
      level_clear  <= 1'b0;
      slot_new     <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        size_q[i]      <= seed_size(i, NUM_LARGE);
        work_size[i]   <= AST_NONE;
        parent_q[i]    <= PW'(i);
        work_parent[i] <= PW'(i);
      end
    end else begin
      points_valid <= 1'b0;
      level_clear  <= 1'b0;
      slot_new     <= '0;
      if (new_level) pend_nl <= 1'b1;

      // Capture: freeze the frame's hits, free mask and working copy.
      if (capture) begin
        hits_frame  <= hit_acc | cur_hit;
        hit_acc     <= '0;
        reseed      <= pend_nl | new_level | ~(|live);
        pend_nl     <= 1'b0;
        free_cap    <= ~live;
        alloc       <= '0;
        new_mask    <= '0;
        pts         <= '0;
        k           <= '0;
        work_size   <= size_q;
        work_parent <= parent_q;
      end else begin
        hit_acc <= hit_acc | cur_hit;
      end

      // Scan: resolve slot k against the working copy.
      if (state_q == ST_SCAN) begin
        k <= k + PW'(1);
        if (hit_k) begin
          work_size[k] <= next_size;
          if (score_en) pts <= pts_sum;
          if (child_size != AST_NONE) begin
            if (found) begin
              work_size[fidx]   <= child_size;
              work_parent[fidx] <= k;
              alloc[fidx]       <= 1'b1;
              new_mask[fidx]    <= 1'b1;
              new_mask[k]       <= 1'b1;
            end else if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
          end
        end
      end

      // Commit: publish sizes, reload pulses and frame points.
      if (state_q == ST_COMMIT) begin
        points_valid <= 1'b1;
        if (reseed) begin
          ast_points <= '0;
          slot_new   <= SEED_MASK;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            size_q[i] <= seed_size(i, NUM_LARGE);
            if (i < NUM_LARGE) parent_q[i] <= PW'(i);
          end
        end else begin
          ast_points  <= pts;
          slot_new    <= new_mask;
          level_clear <= work_empty;
          size_q      <= work_size;
          parent_q    <= work_parent;
        end
      end
    end
  end

  always_comb begin
    slot_size   = '0;
    slot_parent = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_size[2*i +: 2]    = size_q[i];
      slot_parent[PW*i +: PW] = parent_q[i];
    end
  end

endmodule
